// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encoding and NZCV flag bit positions.
// Used by the retire stage and by any branch logic that evaluates conditions.
package cpu_pkg;

    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

    typedef enum logic [3:0] {
        CondEq = 4'h0,
        CondNe = 4'h1,
        CondCs = 4'h2,
        CondCc = 4'h3,
        CondMi = 4'h4,
        CondPl = 4'h5,
        CondVs = 4'h6,
        CondVc = 4'h7,
        CondHi = 4'h8,
        CondLs = 4'h9,
        CondGe = 4'hA,
        CondLt = 4'hB,
        CondGt = 4'hC,
        CondLe = 4'hD,
        CondAl = 4'hE,
        CondNv = 4'hF
    } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: (cond, nzcv) -> pass.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[N_BIT];
    assign z = nzcv[Z_BIT];
    assign c = nzcv[C_BIT];
    assign v = nzcv[V_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            CondEq:  pass = z;
            CondNe:  pass = !z;
            CondCs:  pass = c;
            CondCc:  pass = !c;
            CondMi:  pass = n;
            CondPl:  pass = !n;
            CondVs:  pass = v;
            CondVc:  pass = !v;
            CondHi:  pass = c && !z;
            CondLs:  pass = !c || z;
            CondGe:  pass = (n == v);
            CondLt:  pass = (n != v);
            CondGt:  pass = !z && (n == v);
            CondLe:  pass = z || (n != v);
            CondAl:  pass = 1'b1;
            CondNv:  pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_retire.sv
// ALU retire stage: condition check, architectural NZCV update and a 2-entry writeback buffer.
// Optional failed-condition counter enabled by defining COND_SKIP_CNT_EN.
module alu_flag_retire
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_f,
    input  logic [3:0]        in_nzcv,
    input  logic              in_s,
    input  logic              in_wb,
    input  logic [3:0]        in_cond,
    input  logic [RD_W-1:0]   in_rd,
    output logic              flag_c,
    output logic              flag_v,
    output logic [3:0]        nzcv_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_f,
    output logic [RD_W-1:0]   out_rd,
    output logic [15:0]       skip_cnt
);

    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic              tail;
    logic [DATA_W-1:0] buf_f_q  [2];
    logic [RD_W-1:0]   buf_rd_q [2];

    logic pass;
    logic accept;
    logic push;
    logic pop;
    logic set_flags;

    cond_eval u_cond_eval (
        .cond (in_cond),
        .nzcv (nzcv_q),
        .pass (pass)
    );

    // Ready comes from the registered count only, so a pop cannot free a slot in the same cycle.
    assign in_ready  = (count_q != 2'd2);
    assign accept    = in_valid && in_ready;
    assign push      = accept && pass && in_wb;
    assign set_flags = accept && pass && in_s;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_f     = buf_f_q[head_q];
    assign out_rd    = buf_rd_q[head_q];

    // With one entry held the free slot is the one opposite the head.
    assign tail = head_q ^ (count_q == 2'd1);

    assign flag_c = nzcv_q[C_BIT];
    assign flag_v = nzcv_q[V_BIT];

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        if (pop) begin
            head_d = !head_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 2'd0;
            head_q      <= 1'b0;
            nzcv_q      <= 4'd0;
            buf_f_q[0]  <= '0;
            buf_f_q[1]  <= '0;
            buf_rd_q[0] <= '0;
            buf_rd_q[1] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (set_flags) begin
                nzcv_q <= in_nzcv;
            end
            if (push) begin
                buf_f_q[tail]  <= in_f;
                buf_rd_q[tail] <= in_rd;
            end
        end
    end

`ifdef COND_SKIP_CNT_EN
    logic [15:0] skip_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt_q <= 16'd0;
        end else if (accept && !pass && (skip_cnt_q != 16'hFFFF)) begin
            skip_cnt_q <= skip_cnt_q + 16'd1;
        end
    end

    assign skip_cnt = skip_cnt_q;
`else
    assign skip_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alu_flag_retire.sv
// Self-checking bench for alu_flag_retire: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_alu_flag_retire;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
`ifdef COND_SKIP_CNT_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_f;
    logic [3:0]        in_nzcv;
    logic              in_s;
    logic              in_wb;
    logic [3:0]        in_cond;
    logic [RD_W-1:0]   in_rd;
    logic              flag_c;
    logic              flag_v;
    logic [3:0]        nzcv_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_f;
    logic [RD_W-1:0]   out_rd;
    logic [15:0]       skip_cnt;

    alu_flag_retire #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_f      (in_f),
        .in_nzcv   (in_nzcv),
        .in_s      (in_s),
        .in_wb     (in_wb),
        .in_cond   (in_cond),
        .in_rd     (in_rd),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .nzcv_q    (nzcv_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_rd    (out_rd),
        .skip_cnt  (skip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] f;
    } ent_t;

    ent_t     m_q[$];
    bit [3:0] m_nzcv;
    int       m_skip;
    int       n_cmp = 0;
    int       n_err = 0;

    function automatic bit m_cond(input logic [3:0] c, input bit [3:0] fl);
        bit n, z, cy, v;
        n = fl[3];
        z = fl[2];
        cy = fl[1];
        v = fl[0];
        case (int'(c))
            0:  return z;
            1:  return !z;
            2:  return cy;
            3:  return !cy;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cy && !z;
            9:  return !cy || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] exp_skip();
        return SKIP_EN ? 16'(m_skip) : 16'd0;
    endfunction

    task automatic set_in(input logic v, input logic [DATA_W-1:0] f, input logic [3:0] fl,
                          input logic s, input logic wb, input logic [3:0] c,
                          input logic [RD_W-1:0] rd);
        in_valid = v;
        in_f     = f;
        in_nzcv  = fl;
        in_s     = s;
        in_wb    = wb;
        in_cond  = c;
        in_rd    = rd;
    endtask

    // Advance the model by one clock using the inputs currently driven, then step the DUT.
    task automatic tick();
        bit acc, ps, pop;
        if (rst) begin
            m_q.delete();
            m_nzcv = 4'd0;
            m_skip = 0;
        end else begin
            acc = in_valid && (m_q.size() != 2);
            ps  = m_cond(in_cond, m_nzcv);
            pop = (m_q.size() != 0) && out_ready;
            if (pop) void'(m_q.pop_front());
            if (acc && ps && in_wb) m_q.push_back('{rd: in_rd, f: in_f});
            if (acc && ps && in_s) m_nzcv = in_nzcv;
            if (acc && !ps && m_skip != 65535) m_skip++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        set_in(1'b0, '0, 4'd0, 1'b0, 1'b0, 4'd0, '0);
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (nzcv_q !== 4'd0 || flag_c !== 1'b0 || flag_v !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got nzcv=%b c=%b v=%b want 0000 0 0", nzcv_q, flag_c, flag_v);
        end
        n_cmp++;
        if (out_f !== '0 || out_rd !== '0 || skip_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_data: got f=%h rd=%0d skip=%0d want 0 0 0", out_f, out_rd, skip_cnt);
        end
    endtask

    task automatic test_basic();
        set_in(1'b1, 32'h5, 4'b0110, 1'b1, 1'b1, 4'hE, 5'd3);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (nzcv_q !== 4'b0110 || flag_c !== 1'b1 || flag_v !== 1'b0) begin
            n_err++;
            $display("FAIL basic_flags: got nzcv=%b c=%b v=%b want 0110 1 0", nzcv_q, flag_c, flag_v);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_f !== 32'h5 || out_rd !== 5'd3) begin
            n_err++;
            $display("FAIL basic_push: got v=%b f=%h rd=%0d want 1 5 3", out_valid, out_f, out_rd);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_pop: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_skip();
        set_in(1'b1, 32'h0, 4'b0100, 1'b1, 1'b0, 4'hE, 5'd0);
        tick();
        set_in(1'b1, 32'h1234, 4'b1111, 1'b1, 1'b1, 4'h1, 5'd9);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (nzcv_q !== 4'b0100 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL skip_no_effect: got nzcv=%b out_valid=%b want 0100 0", nzcv_q, out_valid);
        end
        n_cmp++;
        if (skip_cnt !== (SKIP_EN ? 16'd1 : 16'd0)) begin
            n_err++; $display("FAIL skip_cnt: got %0d want %0d", skip_cnt, SKIP_EN ? 1 : 0);
        end
    endtask

    // Stall the consumer, fill the buffer, then drain while a third result is waiting.
    task automatic test_stall_order();
        out_ready = 1'b0;
        set_in(1'b1, 32'hA1, 4'd0, 1'b0, 1'b1, 4'hE, 5'd1);
        tick();
        set_in(1'b1, 32'hA2, 4'd0, 1'b0, 1'b1, 4'hE, 5'd2);
        tick();
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd1) begin
            n_err++;
            $display("FAIL stall_full: got ready=%b valid=%b rd=%0d want 0 1 1", in_ready, out_valid, out_rd);
        end
        set_in(1'b1, 32'hA3, 4'd0, 1'b0, 1'b1, 4'hE, 5'd3);
        tick();
        n_cmp++;
        if (in_ready !== 1'b0 || out_rd !== 5'd1) begin
            n_err++; $display("FAIL stall_hold: got ready=%b rd=%0d want 0 1", in_ready, out_rd);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'd2 || out_f !== 32'hA2) begin
            n_err++;
            $display("FAIL full_pop: got ready=%b valid=%b rd=%0d f=%h want 1 1 2 a2",
                     in_ready, out_valid, out_rd, out_f);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_f !== 32'hA3) begin
            n_err++;
            $display("FAIL push_pop_one: got valid=%b rd=%0d f=%h want 1 3 a3", out_valid, out_rd, out_f);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL drain: got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        set_in(1'b1, 32'h0, 4'b1000, 1'b1, 1'b0, 4'hE, 5'd0);
        tick();
        set_in(1'b1, 32'hABCD, 4'b0000, 1'b0, 1'b1, 4'h4, 5'd7);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_f !== 32'hABCD || nzcv_q !== 4'b1000) begin
            n_err++;
            $display("FAIL back_to_back: got valid=%b rd=%0d f=%h nzcv=%b want 1 7 abcd 1000",
                     out_valid, out_rd, out_f, nzcv_q);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_in(1'b1, 32'h44, 4'b1111, 1'b1, 1'b1, 4'hE, 5'd4);
        tick();
        set_in(1'b1, 32'h55, 4'b0000, 1'b0, 1'b1, 4'hE, 5'd5);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (nzcv_q !== 4'b1111 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL pre_reset: got nzcv=%b ready=%b want 1111 0", nzcv_q, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || nzcv_q !== 4'd0 || in_ready !== 1'b1 || skip_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid: got valid=%b nzcv=%b ready=%b skip=%0d want 0 0000 1 0",
                     out_valid, nzcv_q, in_ready, skip_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 9) < 7), $urandom, 4'($urandom), 1'($urandom),
                   1'($urandom), 4'($urandom), 5'($urandom));
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
            n_cmp++;
            if (in_ready !== (m_q.size() != 2) || out_valid !== (m_q.size() != 0)) begin
                n_err++;
                $display("FAIL rand_hs[%0d]: got ready=%b valid=%b want %b %b", i, in_ready,
                         out_valid, m_q.size() != 2, m_q.size() != 0);
            end
            n_cmp++;
            if (nzcv_q !== m_nzcv || flag_c !== m_nzcv[1] || flag_v !== m_nzcv[0]) begin
                n_err++;
                $display("FAIL rand_flags[%0d]: got nzcv=%b c=%b v=%b want %b", i, nzcv_q,
                         flag_c, flag_v, m_nzcv);
            end
            n_cmp++;
            if (skip_cnt !== exp_skip()) begin
                n_err++; $display("FAIL rand_skip[%0d]: got %0d want %0d", i, skip_cnt, exp_skip());
            end
            if (m_q.size() != 0) begin
                n_cmp++;
                if (out_f !== m_q[0].f || out_rd !== m_q[0].rd) begin
                    n_err++;
                    $display("FAIL rand_head[%0d]: got f=%h rd=%0d want f=%h rd=%0d", i, out_f,
                             out_rd, m_q[0].f, m_q[0].rd);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_stall_order();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
